// File: rtl/calc_pkg.sv
// Shared encodings for the sequenced calculator arithmetic unit.
// Op codes and the control FSM state type.
package calc_pkg;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_ACC = 2'b10;
    localparam logic [1:0] OP_MUL = 2'b11;

    typedef enum logic [1:0] {
        IDLE,
        ALU,
        MUL,
        FIX
    } state_t;

endpackage

// File: rtl/shift_add_mul.sv
// Signed N x N shift-add multiplier on magnitudes with sign fix-up.
// Result and overflow are valid once the run has finished.
module shift_add_mul #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clear,
    input  logic         start,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic         done,
    output logic [N-1:0] res,
    output logic         ovr
);

    localparam int CW = $clog2(N);

    logic           run_q, run_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [2*N-1:0] mcand_q, mcand_d;
    logic [N-1:0]   mplier_q, mplier_d;
    logic [2*N-1:0] acc_q, acc_d;
    logic           sign_q, sign_d;
    logic [N-1:0]   mag_a, mag_b;
    logic [2*N-1:0] prod;

    // Magnitude of the most negative value is exact as an unsigned N-bit number.
    assign mag_a = a[N-1] ? -a : a;
    assign mag_b = b[N-1] ? -b : b;

    always_comb begin
        run_d    = run_q;
        cnt_d    = cnt_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        sign_d   = sign_q;
        if (clear) begin
            run_d    = 1'b0;
            cnt_d    = '0;
            mcand_d  = '0;
            mplier_d = '0;
            acc_d    = '0;
            sign_d   = 1'b0;
        end else if (start) begin
            run_d    = 1'b1;
            cnt_d    = '0;
            mcand_d  = {{N{1'b0}}, mag_a};
            mplier_d = mag_b;
            acc_d    = '0;
            sign_d   = a[N-1] ^ b[N-1];
        end else if (run_q) begin
            if (mplier_q[0]) begin
                acc_d = acc_q + mcand_q;
            end
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            if (cnt_q == CW'(N - 1)) begin
                run_d = 1'b0;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_q    <= 1'b0;
            cnt_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            sign_q   <= 1'b0;
        end else begin
            run_q    <= run_d;
            cnt_q    <= cnt_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            sign_q   <= sign_d;
        end
    end

    assign done = run_q && (cnt_q == CW'(N - 1));
    assign prod = sign_q ? -acc_q : acc_q;
    assign res  = prod[N-1:0];
    // In range only if the upper N+1 bits are a pure sign extension.
    assign ovr  = !((&prod[2*N-1:N-1]) || !(|prod[2*N-1:N-1]));

endmodule

// File: rtl/arith_seq_unit.sv
// Sequenced arithmetic unit: operand/result registers, ALU and control FSM.
// Multiplication is delegated to shift_add_mul.
module arith_seq_unit
    import calc_pkg::*;
#(
    parameter int N = 8
) (
    input  logic         Clock,
    input  logic         Reset,
    input  logic         Clear,
    input  logic [N-1:0] In,
    input  logic         LoadA,
    input  logic         LoadB,
    input  logic         Start,
    input  logic [1:0]   Op,
    output logic         Busy,
    output logic         Done,
    output logic [N-1:0] Result,
    output logic         OVR,
    output logic         Zero,
    output logic         Neg
);

    state_t       state_q, state_d;
    logic [N-1:0] a_q, a_d;
    logic [N-1:0] b_q, b_d;
    logic [N-1:0] r_q, r_d;
    logic         ovr_q, ovr_d;
    logic         done_q, done_d;
    logic [N-1:0] alu_res_q, alu_res_d;
    logic         alu_ovr_q, alu_ovr_d;

    logic [N-1:0] alu_x, alu_y, alu_sum;
    logic         alu_cin, alu_ovr;
    logic         mul_start, mul_done, mul_ovr;
    logic [N-1:0] mul_res;

    // Evaluated on the Start edge so a same-cycle load cannot disturb it.
    always_comb begin
        alu_x   = a_q;
        alu_y   = b_q;
        alu_cin = 1'b0;
        unique case (Op)
            OP_ADD: ;
            OP_SUB: begin
                alu_y   = ~b_q;
                alu_cin = 1'b1;
            end
            OP_ACC: begin
                alu_x = r_q;
                alu_y = a_q;
            end
            OP_MUL: ;
        endcase
        alu_sum = alu_x + alu_y + N'(alu_cin);
        alu_ovr = (alu_x[N-1] == alu_y[N-1]) && (alu_sum[N-1] != alu_x[N-1]);
    end

    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        r_d       = r_q;
        ovr_d     = ovr_q;
        done_d    = 1'b0;
        alu_res_d = alu_res_q;
        alu_ovr_d = alu_ovr_q;
        mul_start = 1'b0;
        if (Clear) begin
            state_d = IDLE;
            a_d     = '0;
            b_d     = '0;
            r_d     = '0;
            ovr_d   = 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (LoadA) a_d = In;
                    if (LoadB) b_d = In;
                    if (Start) begin
                        if (Op == OP_MUL) begin
                            state_d   = MUL;
                            mul_start = 1'b1;
                        end else begin
                            state_d   = ALU;
                            alu_res_d = alu_sum;
                            alu_ovr_d = alu_ovr;
                        end
                    end
                end
                ALU: begin
                    r_d     = alu_res_q;
                    ovr_d   = alu_ovr_q;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
                MUL: begin
                    if (mul_done) state_d = FIX;
                end
                FIX: begin
                    r_d     = mul_res;
                    ovr_d   = mul_ovr;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state_q   <= IDLE;
            a_q       <= '0;
            b_q       <= '0;
            r_q       <= '0;
            ovr_q     <= 1'b0;
            done_q    <= 1'b0;
            alu_res_q <= '0;
            alu_ovr_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            a_q       <= a_d;
            b_q       <= b_d;
            r_q       <= r_d;
            ovr_q     <= ovr_d;
            done_q    <= done_d;
            alu_res_q <= alu_res_d;
            alu_ovr_q <= alu_ovr_d;
        end
    end

    shift_add_mul #(.N(N)) u_mul (
        .clk   (Clock),
        .rst_n (Reset),
        .clear (Clear),
        .start (mul_start),
        .a     (a_q),
        .b     (b_q),
        .done  (mul_done),
        .res   (mul_res),
        .ovr   (mul_ovr)
    );

    assign Busy   = (state_q != IDLE);
    assign Done   = done_q;
    assign Result = r_q;
    assign OVR    = ovr_q;
    assign Zero   = (r_q == '0);
    assign Neg    = r_q[N-1];

endmodule

// File: doc/arith_seq_unit.md
# arith_seq_unit

Parametrised, sequenced successor to the calculator's arithmetic unit. It holds two N-bit signed operand registers and a result register. A Start/Busy/Done handshake runs one of four operations: add, subtract, accumulate, or a multi-cycle shift-add multiply. Result, overflow, zero and negative flags are registered. It sits between the keypad/operand-entry logic and the display driver.

## Interface
- N, default 8: operand/result width in bits, two's complement; N ≥ 2.
- Clock  in  1: rising-edge clock.
- Reset  in  1: asynchronous, active-low reset. Low clears all state immediately.
- Clear  in  1: synchronous clear, active-high.
- In  in  N: operand data bus.
- LoadA  in  1: capture In into A.
- LoadB  in  1: capture In into B.
- Start  in  1: begin the operation selected by Op.
- Op  in  2: operation code. 00 = add (A+B), 01 = sub (A−B), 10 = acc (R+A), 11 = mul (A×B).
- Busy  out  1: high while an operation is in flight.
- Done  out  1: one-cycle pulse when Result/flags update.
- Result  out  N: result register.
- OVR  out  1: signed overflow of the last operation.
- Zero  out  1: Result == 0.
- Neg  out  1: Result[N-1].

## Operation
- States: IDLE, ALU, MUL, FIX. Busy = (state != IDLE).
- IDLE behaviour:
  - LoadA/LoadB capture In; both may load in the same cycle.
  - Start captures Op. Op 00/01/10 go to ALU; Op 11 goes to MUL.
- ALU (one cycle): compute the N-bit sum/difference and write Result. Set OVR per signed overflow (operand signs equal and result sign differs, with B inverted for sub). Pulse Done, return to IDLE.
- MUL entry: load |A| and |B| into working registers, clear the 2N-bit product accumulator, and record sign = A[N-1]^B[N-1].
- MUL (N cycles): each cycle, if multiplier LSB = 1, add multiplicand into the accumulator; shift. A count from 0 to N-1 exits to FIX.
- FIX (one cycle):
  - Negate the product if sign = 1.
  - Result = low N bits.
  - OVR = 1 if the 2N-bit signed product is outside [−2^(N−1), 2^(N−1)−1].
  - Pulse Done, return to IDLE.
- |−2^(N−1)| is formed as an N-bit unsigned magnitude (2^(N−1)). This is legal and exact.
- While Busy:
  - Start, LoadA, LoadB and Op are ignored.
  - A and B hold their values.
- Zero and Neg are combinational from Result. OVR is registered and changes only with Done or a clear/reset.
- Clear (synchronous, any state):
  - A, B, Result and OVR go to 0; state goes to IDLE.
  - An in-flight operation is abandoned with no Done.
  - Clear has priority over Start and the loads in the same cycle.
- Reset low (asynchronous, any time, including mid-MUL): same clear effect as Clear, but immediate.

## Timing
- Reset values:
  - 0: Result, OVR, Busy, Done, A, B, counter.
  - Zero = 1; Neg = 0.
  - State = IDLE.
- Start sampled at edge t0 (Op add/sub/acc): Busy high during t0→t0+1. Result, OVR and Done update at edge t0+1. Done is high for exactly one cycle, and Busy is low in that same cycle.
- Start sampled at edge t0 (Op mul): MUL runs for edges t0+1…t0+N and FIX loads at t0+N+1. Busy is high for N+1 cycles; Done rises at t0+N+1.
- Start may be re-asserted in the Done cycle; it is accepted (state is IDLE).
- A load in the same cycle as Start takes effect after the operation's operand capture. The operation uses the pre-edge A/B.
- No combinational path from inputs to outputs except Zero/Neg from Result.

## Structure
- Package calc_pkg holds:
  - Op encodings OP_ADD, OP_SUB, OP_ACC, OP_MUL.
  - State enum IDLE/ALU/MUL/FIX.
- Sub-module shift_add_mul(N) contains:
  - The MUL/FIX datapath: magnitude registers, 2N-bit accumulator, counter, sign fix-up and overflow range check.
  - A start/done handshake to the top FSM.
- The top level holds the operand/result registers, the ALU adder/subtractor and the control FSM.

## Test plan
All scenarios use N = 8.
- Add, no overflow: A=100, B=27, Start Op=00 → Done at t0+1; Result=127, OVR=0, Neg=0, Zero=0.
- Add overflow, then sub to zero:
  - A=100, B=28, Op=00 → Result=0x80, OVR=1, Neg=1.
  - Then A=5, B=5, Op=01 → Result=0, Zero=1, OVR=0.
- Accumulate: R=0, A=50, Op=10 issued three times → Result 50, 100, then 0x96 with OVR=1.
- Signed multiply:
  - A=−7, B=6, Op=11 → Busy for 9 cycles, Done at t0+9, Result=0xD6 (−42), OVR=0.
  - A=16, B=8 → Result=0x80, OVR=1.
  - A=−128, B=1 → Result=0x80, OVR=0.
- Handshake: Start and LoadA=0x11 asserted during MUL → ignored; A unchanged, a single Done.
- Abort:
  - Clear at t0+4 of a mul → Busy=0 next cycle, no Done, Result=0, Zero=1.
  - Reset low asynchronously mid-mul → all outputs at reset values before the next edge.
